// File: rtl/window_stream.sv
`default_nettype none
// ============================================================================
// Module   : window_stream
// Purpose  : Sliding KxK window generator over a raster pixel stream, with
//            chained line buffers and a single valid/ready output register.
// Revision : 1.0
// ============================================================================
module window_stream #(
    parameter int STREAM_WIDTH = 8,
    parameter int KERNEL_SIZE  = 3,
    parameter int IMAGE_HEIGHT = 226,
    parameter int IMAGE_WIDTH  = 226
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [STREAM_WIDTH-1:0]                          stream_in,
    input  logic                                             stream_in_valid,
    output logic                                             stream_in_ready,
    output logic [STREAM_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0]  stream_out,
    output logic                                             stream_out_valid,
    input  logic                                             stream_out_ready
);
    localparam int c_ROW_W = $clog2(IMAGE_HEIGHT);
    localparam int c_COL_W = $clog2(IMAGE_WIDTH);
    localparam int c_OUT_W = STREAM_WIDTH * KERNEL_SIZE * KERNEL_SIZE;

    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMAGE_WIDTH - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_EMIT = c_ROW_W'(KERNEL_SIZE - 1);
    localparam logic [c_COL_W-1:0] c_COL_EMIT = c_COL_W'(KERNEL_SIZE - 1);

    logic [c_ROW_W-1:0]      r_row;
    logic [c_COL_W-1:0]      r_col;
    logic [STREAM_WIDTH-1:0] r_lb       [KERNEL_SIZE-1][IMAGE_WIDTH];
    logic [STREAM_WIDTH-1:0] r_win      [KERNEL_SIZE][KERNEL_SIZE];
    logic [STREAM_WIDTH-1:0] w_win_next [KERNEL_SIZE][KERNEL_SIZE];
    logic [STREAM_WIDTH-1:0] w_lb_rd    [KERNEL_SIZE-1];
    logic [c_OUT_W-1:0]      w_out_flat;
    logic [c_OUT_W-1:0]      r_out;
    logic                    r_out_valid;
    logic                    w_accept;
    logic                    w_emit;

    assign stream_in_ready  = ~r_out_valid | stream_out_ready;
    assign w_accept         = stream_in_valid & stream_in_ready;
    assign w_emit           = w_accept & (r_row >= c_ROW_EMIT) & (r_col >= c_COL_EMIT);
    assign stream_out       = r_out;
    assign stream_out_valid = r_out_valid;

    always_comb begin
        for (int j = 0; j < KERNEL_SIZE - 1; j++) begin
            w_lb_rd[j] = r_lb[j][r_col];
        end
    end

    // Bottom row takes the live pixel; row r above it takes the buffer holding
    // the pixel from (K-1-r) rows earlier in the same column.
    always_comb begin
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                w_win_next[r][c] = r_win[r][c+1];
            end
            if (r == KERNEL_SIZE - 1) begin
                w_win_next[r][KERNEL_SIZE-1] = stream_in;
            end else begin
                w_win_next[r][KERNEL_SIZE-1] = w_lb_rd[KERNEL_SIZE-2-r];
            end
        end
    end

    for (genvar r = 0; r < KERNEL_SIZE; r++) begin : g_row
        for (genvar c = 0; c < KERNEL_SIZE; c++) begin : g_col
            assign w_out_flat[((r*KERNEL_SIZE)+c)*STREAM_WIDTH +: STREAM_WIDTH] = w_win_next[r][c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            if (r_col == c_COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb[0][r_col] <= stream_in;
            for (int j = 1; j < KERNEL_SIZE - 1; j++) begin
                r_lb[j][r_col] <= w_lb_rd[j-1];
            end
            r_win <= w_win_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_emit) begin
            r_out <= w_out_flat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
        end else if (w_emit) begin
            r_out_valid <= 1'b1;
        end else if (stream_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_window_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_stream
// Purpose  : Directed/table-driven bench for window_stream (K=3 5x5, K=2 3x4).
// Revision : 1.0
// ============================================================================
module tb_window_stream;
    localparam int SW  = 8;
    localparam int KA  = 3, HA = 5, WA = 5;
    localparam int KB  = 2, HB = 3, WB = 4;
    localparam int OWA = SW*KA*KA;
    localparam int OWB = SW*KB*KB;
    localparam int NPA = HA*WA;
    localparam int NWA = (HA-KA+1)*(WA-KA+1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [SW-1:0]  a_in,  b_in;
    logic           a_iv,  a_ir, a_ov, a_or;
    logic           b_iv,  b_ir, b_ov, b_or;
    logic [OWA-1:0] a_out;
    logic [OWB-1:0] b_out;

    window_stream #(.STREAM_WIDTH(SW), .KERNEL_SIZE(KA), .IMAGE_HEIGHT(HA), .IMAGE_WIDTH(WA)) u_dut_a (
        .clk(clk), .rst(rst),
        .stream_in(a_in), .stream_in_valid(a_iv), .stream_in_ready(a_ir),
        .stream_out(a_out), .stream_out_valid(a_ov), .stream_out_ready(a_or)
    );

    window_stream #(.STREAM_WIDTH(SW), .KERNEL_SIZE(KB), .IMAGE_HEIGHT(HB), .IMAGE_WIDTH(WB)) u_dut_b (
        .clk(clk), .rst(rst),
        .stream_in(b_in), .stream_in_valid(b_iv), .stream_in_ready(b_ir),
        .stream_out(b_out), .stream_out_valid(b_ov), .stream_out_ready(b_or)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [OWA-1:0] cap_a[$];
    int             cap_cyc[$];
    int             acc_cyc[NPA];
    logic [OWB-1:0] cap_b[$];

    typedef struct {
        int             idx;
        logic [OWA-1:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Window whose top-left pixel has value tl, in a frame where value = base + pos + 1.
    function automatic logic [OWA-1:0] win_a(input int tl);
        logic [OWA-1:0] w;
        for (int r = 0; r < KA; r++)
            for (int c = 0; c < KA; c++)
                w[((r*KA)+c)*SW +: SW] = SW'(tl + r*WA + c);
        return w;
    endfunction

    function automatic logic [OWB-1:0] win_b(input int tl);
        logic [OWB-1:0] w;
        for (int r = 0; r < KB; r++)
            for (int c = 0; c < KB; c++)
                w[((r*KB)+c)*SW +: SW] = SW'(tl + r*WB + c);
        return w;
    endfunction

    // Streams nframes frames into DUT A; frame f pixel p carries base0 + f*fstride + p + 1.
    task automatic run_a(input int nframes, input int base0, input int fstride,
                         input int vpct, input int rpct, input bit stall);
        int             sent   = 0;
        int             total  = nframes * NPA;
        int             budget = 3000;
        int             st     = 0;
        bit             done_stall = 0;
        logic [OWA-1:0] held = '0;
        cap_a.delete();
        cap_cyc.delete();
        while ((sent < total || cap_a.size() < nframes*NWA || a_ov) && budget > 0) begin
            budget--;
            @(posedge clk); #1;
            if (stall && !done_stall && a_ov) begin
                done_stall = 1;
                st   = 4;
                held = a_out;
            end
            a_iv = (sent < total) && ($urandom_range(0, 99) < vpct);
            a_in = SW'(base0 + (sent / NPA) * fstride + (sent % NPA) + 1);
            a_or = (st > 0) ? 1'b0 : ($urandom_range(0, 99) < rpct);
            @(negedge clk);
            if (st > 0) begin
                chk("stall_out_stable", a_out, held);
                chk("stall_in_ready",   a_ir,  0);
                chk("stall_out_valid",  a_ov,  1);
                st--;
            end
            if (a_iv && a_ir) begin
                acc_cyc[sent % NPA] = cyc;
                sent++;
            end
            if (a_ov && a_or) begin
                cap_a.push_back(a_out);
                cap_cyc.push_back(cyc);
            end
        end
        @(posedge clk); #1;
        a_iv = 1'b0;
        a_or = 1'b1;
        chk("a_timeout", budget > 0, 1);
        chk("a_win_count", cap_a.size(), nframes*NWA);
        for (int i = 0; i < cap_a.size() && i < nframes*NWA; i++) begin
            int f  = i / NWA;
            int w  = i % NWA;
            int tl = base0 + f*fstride + (w / (WA-KA+1))*WA + (w % (WA-KA+1)) + 1;
            chk($sformatf("a_win_f%0d_w%0d", f, w), cap_a[i], win_a(tl));
        end
    endtask

    vec_t basic_tbl[4];

    initial begin
        rst  = 1'b1;
        a_in = '0; a_iv = 1'b0; a_or = 1'b1;
        b_in = '0; b_iv = 1'b0; b_or = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_a_out_valid", a_ov, 0);
        chk("rst_a_in_ready",  a_ir, 1);
        chk("rst_b_out_valid", b_ov, 0);
        chk("rst_b_in_ready",  b_ir, 1);

        // Basic frame, continuous flow
        basic_tbl[0] = '{0, {8'd13, 8'd12, 8'd11, 8'd8,  8'd7,  8'd6,  8'd3,  8'd2,  8'd1}};
        basic_tbl[1] = '{3, {8'd18, 8'd17, 8'd16, 8'd13, 8'd12, 8'd11, 8'd8,  8'd7,  8'd6}};
        basic_tbl[2] = '{4, {8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12, 8'd9,  8'd8,  8'd7}};
        basic_tbl[3] = '{8, {8'd25, 8'd24, 8'd23, 8'd20, 8'd19, 8'd18, 8'd15, 8'd14, 8'd13}};
        run_a(1, 0, 0, 100, 100, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("basic_tbl_%0d", basic_tbl[i].idx),
                (basic_tbl[i].idx < cap_a.size()) ? cap_a[basic_tbl[i].idx] : 'x,
                basic_tbl[i].exp);
        end
        chk("first_win_latency", (cap_cyc.size() > 0) ? cap_cyc[0] : -1, acc_cyc[12] + 1);
        chk("row_edge_latency",  (cap_cyc.size() > 3) ? cap_cyc[3] : -1, acc_cyc[17] + 1);

        // Backpressure: same frame, output stalled 4 cycles on the first window
        run_a(1, 0, 0, 100, 100, 1);

        // Random throttling over 3 back-to-back frames with distinct pixel ranges
        run_a(3, 50, 50, 50, 50, 0);

        // Reset mid-frame after pixel 14
        for (int p = 1; p <= 14; p++) begin
            @(posedge clk); #1;
            a_iv = 1'b1; a_in = SW'(p); a_or = 1'b1;
        end
        @(posedge clk); #1;
        a_iv = 1'b0; a_or = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("pre_rst_window_valid", a_ov, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", a_ov, 0);
        run_a(1, 100, 0, 100, 100, 0);
        chk("post_rst_first_win", (cap_a.size() > 0) ? cap_a[0] : 'x,
            {8'd113, 8'd112, 8'd111, 8'd108, 8'd107, 8'd106, 8'd103, 8'd102, 8'd101});

        // K=2, 3x4 image
        cap_b.delete();
        for (int p = 1; p <= HB*WB + 3; p++) begin
            @(posedge clk); #1;
            b_iv = (p <= HB*WB);
            b_in = SW'(p);
            @(negedge clk);
            if (b_ov) cap_b.push_back(b_out);
        end
        b_iv = 1'b0;
        chk("b_win_count", cap_b.size(), 6);
        chk("b_first_win", (cap_b.size() > 0) ? cap_b[0] : 'x, {8'd6,  8'd5,  8'd2, 8'd1});
        chk("b_last_win",  (cap_b.size() > 5) ? cap_b[5] : 'x, {8'd12, 8'd11, 8'd8, 8'd7});
        for (int i = 0; i < cap_b.size() && i < 6; i++) begin
            chk($sformatf("b_win_%0d", i), cap_b[i], win_b((i / 3)*WB + (i % 3) + 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
